// File: rtl/mips_test_pkg.sv
// Shared types and defaults for the MIPS run controller/checker.
package mips_test_pkg;

    localparam int unsigned ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_RESET = 3'd1,
        ST_RUN   = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } run_state_e;

    localparam logic [31:0] DEF_MISR_POLY  = 32'h04C11DB7;
    localparam logic [31:0] DEF_END_MARKER = 32'hDEADBEEF;

    // Verdict flags reported once a run finishes.
    typedef struct packed {
        logic pass;
        logic fail;
        logic timeout;
    } run_flags_t;

endpackage

// File: rtl/misr_reg.sv
// Multiple-input signature register compressing the CPU test data stream.
module misr_reg
    import mips_test_pkg::*;
#(
    parameter int unsigned        DATA_W    = 32,
    parameter logic [DATA_W-1:0]  MISR_POLY = DATA_W'(DEF_MISR_POLY),
    parameter logic [DATA_W-1:0]  SIG_SEED  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] sig
);

    logic [DATA_W-1:0] sig_q;
    logic [DATA_W-1:0] sig_d;

    // Galois-style step: shift left, feed back the polynomial on MSB, fold in the data word.
    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = SIG_SEED;
        end else if (shift) begin
            sig_d = {sig_q[DATA_W-2:0], 1'b0}
                  ^ (sig_q[DATA_W-1] ? MISR_POLY : '0)
                  ^ din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_q <= SIG_SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/cpu_run_monitor.sv
// Run controller for a MIPS CPU: sequences its reset, counts run cycles, signs the
// test output stream and reports pass/fail/timeout when the end marker appears.
module cpu_run_monitor
    import mips_test_pkg::*;
#(
    parameter int unsigned        DATA_W       = 32,
    parameter int unsigned        CNT_W        = 16,
    parameter int unsigned        RST_HOLD     = 4,
    parameter int unsigned        TIMEOUT      = 1024,
    parameter logic [DATA_W-1:0]  MISR_POLY    = DATA_W'(DEF_MISR_POLY),
    parameter logic [DATA_W-1:0]  SIG_SEED     = '0,
    parameter logic [DATA_W-1:0]  END_MARKER   = DATA_W'(DEF_END_MARKER),
    parameter logic [DATA_W-1:0]  EXPECTED_SIG = '0,
    parameter bit                 CHECK_SIG    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              test_valid,
    input  logic [DATA_W-1:0] test_data,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycles,
    output logic [DATA_W-1:0] signature
);

    localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);

    run_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    run_flags_t        flags_q, flags_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              misr_load;
    logic              misr_shift;
    logic              marker_hit;
    logic              timeout_hit;
    logic              sig_ok;

    assign marker_hit  = test_valid && (test_data == END_MARKER);
    assign timeout_hit = (cycles_q == CNT_W'(TIMEOUT - 1));
    assign sig_ok      = CHECK_SIG ? (signature == EXPECTED_SIG) : 1'b1;

    // Next state, counters, flags and registered-output next values.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        cycles_d   = cycles_q;
        flags_d    = flags_q;
        misr_load  = 1'b0;
        misr_shift = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            flags_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d   = ST_RESET;
                        hold_d    = '0;
                        cycles_d  = '0;
                        flags_d   = '0;
                        misr_load = 1'b1;
                    end
                end
                ST_RESET: begin
                    if (hold_q == HOLD_W'(RST_HOLD - 1)) begin
                        state_d = ST_RUN;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    // Marker beats a coincident timeout; the timeout cycle leaves the count at TIMEOUT-1.
                    if (marker_hit) begin
                        state_d = ST_CHECK;
                    end else if (timeout_hit) begin
                        state_d = ST_DONE;
                        flags_d = '{pass: 1'b0, fail: 1'b1, timeout: 1'b1};
                    end else begin
                        misr_shift = test_valid;
                    end
                    if (marker_hit || !timeout_hit) begin
                        cycles_d = (cycles_q == '1) ? cycles_q : cycles_q + CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    state_d = ST_DONE;
                    flags_d = '{pass: sig_ok, fail: !sig_ok, timeout: 1'b0};
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        cpu_rst_n_d = (state_d == ST_RUN);
        busy_d      = (state_d == ST_RESET) || (state_d == ST_RUN) || (state_d == ST_CHECK);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            cycles_q    <= '0;
            flags_q     <= '0;
            cpu_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            cycles_q    <= cycles_d;
            flags_q     <= flags_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    misr_reg #(
        .DATA_W    (DATA_W),
        .MISR_POLY (MISR_POLY),
        .SIG_SEED  (SIG_SEED)
    ) u_misr (
        .clk   (clk),
        .rst   (rst),
        .load  (misr_load),
        .shift (misr_shift),
        .din   (test_data),
        .sig   (signature)
    );

    assign cpu_rst_n = cpu_rst_n_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = flags_q.pass;
    assign fail      = flags_q.fail;
    assign timeout   = flags_q.timeout;
    assign cycles    = cycles_q;

endmodule
